// File: rtl/key_pkg.sv
// Shared definitions for the multi-channel key debouncer: a ceiling-log2
// helper, the default board timing, and the cycle counts derived from it.
package key_pkg;

  // Smallest r such that 2**r >= value (0 for value <= 1).
  function automatic int clog2(input longint value);
    int     r;
    longint v;
    r = 0;
    v = value - 64'sd1;
    while (v > 64'sd0) begin
      r = r + 1;
      v = v >>> 1;
    end
    return r;
  endfunction

  // Board timing defaults.
  localparam int KEY_CLK_HZ      = 50000000;
  localparam int KEY_DEBOUNCE_MS = 10;
  localparam int KEY_LONG_MS     = 1000;

  // Derived cycle counts used as parameter defaults.
  localparam int KEY_STABLE_CYCLES = (KEY_CLK_HZ / 1000) * KEY_DEBOUNCE_MS;
  localparam int KEY_LONG_CYCLES   = (KEY_CLK_HZ / 1000) * KEY_LONG_MS;

  // Counter width large enough that neither count can reach 2**CNT_W.
  localparam int KEY_MAX_CYCLES = (KEY_STABLE_CYCLES > KEY_LONG_CYCLES) ?
                                  KEY_STABLE_CYCLES : KEY_LONG_CYCLES;
  localparam int KEY_CNT_W      = clog2(longint'(KEY_MAX_CYCLES) + 64'sd1);

endpackage

// File: rtl/key_debounce_chan.sv
// One key channel: two-flop synchroniser, stability counter that accepts a
// new level only after STABLE_CYCLES consecutive differing samples, and a
// hold counter that emits a single long-press pulse per press.
module key_debounce_chan
  import key_pkg::*;
#(
  parameter int STABLE_CYCLES = KEY_STABLE_CYCLES,
  parameter int ACTIVE_LOW    = 1,
  parameter int LONG_CYCLES   = KEY_LONG_CYCLES,
  parameter int CNT_W         = KEY_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  // Raw pin level when the key is not pressed; also the XOR mask that turns
  // the synchronised pin into a logical "pressed" bit.
  localparam logic INACTIVE_RAW = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic [CNT_W-1:0] DCNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             sync1_r;
  logic             sync2_r;
  logic             logical_s;
  logic             accept_s;
  logic [CNT_W-1:0] dcnt_r;

  // Two-flop synchroniser, parked at the idle pin level in reset so that no
  // phantom press is counted right after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= INACTIVE_RAW;
      sync2_r <= INACTIVE_RAW;
    end else begin
      sync1_r <= key_in;
      sync2_r <= sync1_r;
    end
  end

  // Polarity-independent view of the key and the "count completed" decision.
  always_comb begin
    logical_s = sync2_r ^ INACTIVE_RAW;
    if ((logical_s != key_level) && (dcnt_r == DCNT_LAST)) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
  end

  // Stability counter: any sample that agrees with the current level
  // restarts the count, so only an unbroken run changes key_level.
  always_ff @(posedge clk) begin
    if (rst) begin
      dcnt_r      <= {CNT_W{1'b0}};
      key_level   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else if (logical_s == key_level) begin
      dcnt_r      <= {CNT_W{1'b0}};
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else if (accept_s) begin
      dcnt_r      <= {CNT_W{1'b0}};
      key_level   <= logical_s;
      key_press   <= logical_s;
      key_release <= ~logical_s;
    end else begin
      dcnt_r      <= dcnt_r + CNT_W'(1);
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end
  end

  generate
    if (LONG_CYCLES > 0) begin : gen_long
      localparam logic [CNT_W-1:0] HCNT_LAST = CNT_W'(LONG_CYCLES - 1);
      localparam logic [CNT_W-1:0] HCNT_SAT  = CNT_W'(LONG_CYCLES);

      logic [CNT_W-1:0] hcnt_r;
      logic             falling_s;

      // A release decided this cycle must not also produce a long pulse.
      always_comb begin
        if (accept_s && !logical_s) begin
          falling_s = 1'b1;
        end else begin
          falling_s = 1'b0;
        end
      end

      // Hold counter: zero while released and in the press cycle, counts
      // while held, and parks at LONG_CYCLES after firing so it never repeats.
      always_ff @(posedge clk) begin
        if (rst) begin
          hcnt_r   <= {CNT_W{1'b0}};
          key_long <= 1'b0;
        end else if (!key_level || falling_s) begin
          hcnt_r   <= {CNT_W{1'b0}};
          key_long <= 1'b0;
        end else if (hcnt_r == HCNT_LAST) begin
          hcnt_r   <= HCNT_SAT;
          key_long <= 1'b1;
        end else if (hcnt_r == HCNT_SAT) begin
          hcnt_r   <= hcnt_r;
          key_long <= 1'b0;
        end else begin
          hcnt_r   <= hcnt_r + CNT_W'(1);
          key_long <= 1'b0;
        end
      end
    end else begin : gen_no_long
      // Long-press detection disabled.
      always_comb begin
        key_long = 1'b0;
      end
    end
  endgenerate

endmodule

// File: rtl/key_debounce_multi.sv
// Multi-channel key debouncer: N_KEYS fully independent channels, each
// producing a clean level plus press, release and long-press pulses.
module key_debounce_multi
  import key_pkg::*;
#(
  parameter int N_KEYS        = 4,
  parameter int STABLE_CYCLES = KEY_STABLE_CYCLES,
  parameter int ACTIVE_LOW    = 1,
  parameter int LONG_CYCLES   = KEY_LONG_CYCLES,
  parameter int CNT_W         = KEY_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_long
);

  generate
    for (genvar i = 0; i < N_KEYS; i++) begin : gen_chan
      key_debounce_chan #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .ACTIVE_LOW    (ACTIVE_LOW),
        .LONG_CYCLES   (LONG_CYCLES),
        .CNT_W         (CNT_W)
      ) u_chan (
        .clk         (clk),
        .rst         (rst),
        .key_in      (key_in[i]),
        .key_level   (key_level[i]),
        .key_press   (key_press[i]),
        .key_release (key_release[i]),
        .key_long    (key_long[i])
      );
    end
  endgenerate

endmodule
